voice_allocator: RTL and testbench

Polyphonic voice allocator between the debounced key bus and `channel_mixer`. It turns key press and release edges into a per-channel enable, pitch and waveform assignment. With fewer mixer channels than keys, every held key still gets a channel while one is free, and the oldest sounding voice is stolen when all channels are busy. In PLAY mode it replaces the fixed key-to-channel wiring. When `ena` is low (DEMO mode), all voices are released so `demo_decoder` owns the mixer.

---
 rtl/voice_allocator.sv | 154 +++++++++++++++
 tb/tb_voice_allocator.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: turns key press/release edges into voice assignments for the mixer,
// stealing the oldest voice when every channel is busy.
module voice_allocator #(
    parameter int NUM_KEYS   = 8,
    parameter int NUM_VOICES = 4,
    parameter int PITCH_W    = 12,
    parameter int AGE_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_b,
    input  logic                          ena,
    input  logic [NUM_KEYS-1:0]           keys,
    input  logic [NUM_KEYS*PITCH_W-1:0]   key_pitches,
    input  logic [1:0]                    waveform,
    output logic [NUM_VOICES-1:0]         channel_ena,
    output logic [NUM_VOICES*PITCH_W-1:0] pitches,
    output logic [NUM_VOICES*2-1:0]       waveforms,
    output logic                          steal,
    output logic                          busy
);
    localparam int KW = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1;
    localparam int VW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef enum logic {IDLE, COMMIT} state_t;
    state_t state, state_nx;

    logic [NUM_KEYS-1:0]   keys_q, pend_on, pend_off, prs_edge, rel_edge;
    logic [NUM_KEYS-1:0]   sel_vec, sel_1h, clr_on, clr_off, pend_on_nx, pend_off_nx;
    logic [NUM_VOICES-1:0] active;
    logic [KW-1:0]         owner [NUM_VOICES];
    logic [PITCH_W-1:0]    pitch [NUM_VOICES];
    logic [AGE_W-1:0]      age   [NUM_VOICES];
    logic [AGE_W-1:0]      old_age;
    logic [KW-1:0]         sel_key, cap_key;
    logic [VW-1:0]         own_idx, free_idx, old_idx, tgt, cap_voice;
    logic                  sel_rel, own_hit, free_hit, cap_go, cap_rel, cap_noop;

    assign prs_edge    = keys & ~keys_q;
    assign rel_edge    = ~keys & keys_q;
    assign channel_ena = active;
    assign waveforms   = {NUM_VOICES{waveform}};

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_pitch
        assign pitches[v*PITCH_W +: PITCH_W] = pitch[v];
    end

    // Releases drain before presses; within each class the lowest key index goes first.
    always_comb begin
        sel_rel = |pend_off;
        sel_vec = sel_rel ? pend_off : pend_on;
        sel_key = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (sel_vec[i]) sel_key = KW'(i);
        sel_1h = '0;
        sel_1h[sel_key] = 1'b1;
        own_hit  = 1'b0;
        own_idx  = '0;
        free_hit = 1'b0;
        free_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (active[i] && owner[i] == sel_key) begin
                own_hit = 1'b1;
                own_idx = VW'(i);
            end
            if (!active[i]) begin
                free_hit = 1'b1;
                free_idx = VW'(i);
            end
        end
        old_idx = '0;
        old_age = age[0];
        for (int i = 1; i < NUM_VOICES; i++)
            if (age[i] > old_age) begin
                old_idx = VW'(i);
                old_age = age[i];
            end
        tgt = own_hit ? own_idx : free_hit ? free_idx : old_idx;
    end

    always_comb begin
        cap_go   = state == IDLE && (|pend_on || |pend_off);
        state_nx = cap_go ? COMMIT : IDLE;
        busy     = state == COMMIT || |pend_on || |pend_off;
    end

    // A fresh edge on the captured key overrides the capture clear.
    always_comb begin
        clr_on      = cap_go && !sel_rel ? sel_1h : '0;
        clr_off     = cap_go && sel_rel ? sel_1h : '0;
        pend_on_nx  = (pend_on & ~clr_on & ~rel_edge) | prs_edge;
        pend_off_nx = (pend_off & ~clr_off & ~prs_edge) | rel_edge;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            state <= IDLE;
        else
            state <= ena ? state_nx : IDLE;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            keys_q    <= '0;
            pend_on   <= '0;
            pend_off  <= '0;
            active    <= '0;
            steal     <= 1'b0;
            cap_key   <= '0;
            cap_rel   <= 1'b0;
            cap_noop  <= 1'b0;
            cap_voice <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                owner[v] <= '0;
                pitch[v] <= '0;
                age[v]   <= '0;
            end
        end else begin
            keys_q <= keys;
            steal  <= 1'b0;
            if (!ena) begin
                pend_on  <= '0;
                pend_off <= '0;
                active   <= '0;
            end else begin
                pend_on  <= pend_on_nx;
                pend_off <= pend_off_nx;
                if (cap_go) begin
                    cap_key   <= sel_key;
                    cap_rel   <= sel_rel;
                    cap_noop  <= sel_rel && !own_hit;
                    cap_voice <= tgt;
                end
                if (state == COMMIT) begin
                    if (cap_rel) begin
                        if (!cap_noop) active[cap_voice] <= 1'b0;
                    end else begin
                        steal <= active[cap_voice] && owner[cap_voice] != cap_key;
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (VW'(v) == cap_voice) begin
                                active[v] <= 1'b1;
                                owner[v]  <= cap_key;
                                pitch[v]  <= key_pitches[int'(cap_key)*PITCH_W +: PITCH_W];
                                age[v]    <= '0;
                            end else if (active[v] && age[v] != AGE_MAX) begin
                                age[v] <= age[v] + 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: table-driven directed checks of allocation, stealing, queueing and enable/reset behaviour.
module tb_voice_allocator;
    localparam int NK = 8, NV = 4, PW = 12;

    logic              clk = 1'b0, rst_b = 1'b0, ena = 1'b0;
    logic [NK-1:0]     keys = '0;
    logic [NK*PW-1:0]  key_pitches;
    logic [1:0]        waveform = 2'd2;
    logic [NV-1:0]     channel_ena;
    logic [NV*PW-1:0]  pitches;
    logic [NV*2-1:0]   waveforms;
    logic              steal, busy;
    int checks = 0, errors = 0;

    typedef struct {
        logic          ena;
        logic [NK-1:0] keys;
        logic [NV-1:0] ch;
        logic          stl;
        logic          bsy;
        int            pv;
        logic [PW-1:0] pval;
    } vec_t;
    vec_t tv[$];

    always #5 clk = ~clk;

    voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .PITCH_W(PW), .AGE_W(8)) dut (
        .clk(clk), .rst_b(rst_b), .ena(ena), .keys(keys), .key_pitches(key_pitches),
        .waveform(waveform), .channel_ena(channel_ena), .pitches(pitches),
        .waveforms(waveforms), .steal(steal), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic [NK-1:0] k, input logic [NV-1:0] ch,
                       input logic stl, input logic bsy, input int pv = -1, input int pval = 0);
        vec_t v;
        v.ena = e; v.keys = k; v.ch = ch; v.stl = stl; v.bsy = bsy; v.pv = pv; v.pval = PW'(pval);
        tv.push_back(v);
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            ena  = tv[i].ena;
            keys = tv[i].keys;
            @(posedge clk); #1;
            chk($sformatf("row%0d channel_ena", i), channel_ena, tv[i].ch);
            chk($sformatf("row%0d steal", i), steal, tv[i].stl);
            chk($sformatf("row%0d busy", i), busy, tv[i].bsy);
            if (tv[i].pv >= 0)
                chk($sformatf("row%0d pitch v%0d", i, tv[i].pv), pitches[tv[i].pv*PW +: PW], tv[i].pval);
        end
    endtask

    task automatic ages(input string name, input int a0, input int a1, input int a2, input int a3);
        chk({name, " age0"}, dut.age[0], a0);
        chk({name, " age1"}, dut.age[1], a1);
        chk({name, " age2"}, dut.age[2], a2);
        chk({name, " age3"}, dut.age[3], a3);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n1, n2;
        for (int k = 0; k < NK; k++) key_pitches[k*PW +: PW] = PW'(200 + 4*k);

        // single press of key 3, then its release
        add(1, 8'h08, 4'h0, 0, 1); add(1, 8'h08, 4'h0, 0, 1); add(1, 8'h08, 4'h1, 0, 0, 0, 212);
        add(1, 8'h00, 4'h1, 0, 1); add(1, 8'h00, 4'h1, 0, 1); add(1, 8'h00, 4'h0, 0, 0);
        // keys 0..3 together fill voices 0..3 one every two cycles
        add(1, 8'h0F, 4'h0, 0, 1); add(1, 8'h0F, 4'h0, 0, 1);
        add(1, 8'h0F, 4'h1, 0, 1, 0, 200); add(1, 8'h0F, 4'h1, 0, 1);
        add(1, 8'h0F, 4'h3, 0, 1, 1, 204); add(1, 8'h0F, 4'h3, 0, 1);
        add(1, 8'h0F, 4'h7, 0, 1, 2, 208); add(1, 8'h0F, 4'h7, 0, 1);
        add(1, 8'h0F, 4'hF, 0, 0, 3, 212);
        n1 = tv.size();
        // key 5 steals voice 0
        add(1, 8'h2F, 4'hF, 0, 1); add(1, 8'h2F, 4'hF, 0, 1);
        add(1, 8'h2F, 4'hF, 1, 0, 0, 220); add(1, 8'h2F, 4'hF, 0, 0);
        n2 = tv.size();
        // release key 1 and press key 6 together
        add(1, 8'h6D, 4'hF, 0, 1); add(1, 8'h6D, 4'hF, 0, 1); add(1, 8'h6D, 4'hD, 0, 1);
        add(1, 8'h6D, 4'hD, 0, 1); add(1, 8'h6D, 4'hF, 0, 0, 1, 224);
        // release of stolen key 0 is a no-op
        add(1, 8'h6C, 4'hF, 0, 1); add(1, 8'h6C, 4'hF, 0, 1); add(1, 8'h6C, 4'hF, 0, 0); add(1, 8'h6C, 4'hF, 0, 0);
        // release keys 2,3 leaving two voices active
        add(1, 8'h60, 4'hF, 0, 1); add(1, 8'h60, 4'hF, 0, 1); add(1, 8'h60, 4'hB, 0, 1);
        add(1, 8'h60, 4'hB, 0, 1); add(1, 8'h60, 4'h3, 0, 0);
        // press key 7, drop ena for one cycle while pending
        add(1, 8'hE0, 4'h3, 0, 1); add(0, 8'hE0, 4'h0, 0, 0);
        add(1, 8'hE0, 4'h0, 0, 0); add(1, 8'hE0, 4'h0, 0, 0); add(1, 8'hE0, 4'h0, 0, 0);
        // release then fresh press of key 7
        add(1, 8'h60, 4'h0, 0, 1); add(1, 8'h60, 4'h0, 0, 1); add(1, 8'h60, 4'h0, 0, 0);
        add(1, 8'hE0, 4'h0, 0, 1); add(1, 8'hE0, 4'h0, 0, 1); add(1, 8'hE0, 4'h1, 0, 0, 0, 228);
        // key 4 pressed and released before capture: only the release remains
        add(1, 8'hF1, 4'h1, 0, 1); add(1, 8'hE1, 4'h1, 0, 1); add(1, 8'hE1, 4'h3, 0, 1, 1, 200);
        add(1, 8'hE1, 4'h3, 0, 1); add(1, 8'hE1, 4'h3, 0, 0); add(1, 8'hE1, 4'h3, 0, 0);

        #12;
        chk("reset channel_ena", channel_ena, 0);
        chk("reset pitches", pitches, 0);
        chk("reset steal", steal, 0);
        chk("reset busy", busy, 0);
        chk("waveforms", waveforms, 8'hAA);
        @(negedge clk);
        rst_b = 1'b1;
        ena   = 1'b1;
        @(posedge clk); #1;

        run(0, n1);
        ages("full", 3, 2, 1, 0);
        run(n1, n2);
        ages("steal", 0, 3, 2, 1);
        run(n2, tv.size());

        waveform = 2'd1; #1;
        chk("waveforms passthrough", waveforms, 8'h55);

        // reset asserted during COMMIT drops the commit immediately
        keys = 8'hE9;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre-reset busy", busy, 1);
        rst_b = 1'b0; #1;
        chk("midcommit channel_ena", channel_ena, 0);
        chk("midcommit pitches", pitches, 0);
        chk("midcommit busy", busy, 0);
        keys = '0;
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("postreset%0d channel_ena", i), channel_ena, 0);
            chk($sformatf("postreset%0d busy", i), busy, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
